// File: rtl/rasterizer_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port among NREQ rasterizer units.
// A grant is held for a run of back-to-back transfers, capped at HOLD_MAX accepts.
// Accepted reads are tagged in a FIFO so returning data reaches the requester that issued it.
module rasterizer_bus_arbiter #(
    parameter int unsigned NREQ            = 3,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned HOLD_MAX        = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [25:0]     req_address       [NREQ],
    input  logic            req_read          [NREQ],
    input  logic            req_write         [NREQ],
    input  logic [3:0]      req_byteenable    [NREQ],
    input  logic [31:0]     req_writedata     [NREQ],
    output logic            req_waitrequest   [NREQ],
    output logic [31:0]     req_readdata,
    output logic            req_readdatavalid [NREQ],
    output logic [25:0]     master_address,
    output logic            master_read,
    output logic            master_write,
    output logic [3:0]      master_byteenable,
    output logic [31:0]     master_writedata,
    input  logic [31:0]     master_readdata,
    input  logic            master_readdatavalid,
    input  logic            master_waitrequest,
    output logic [NREQ-1:0] grant,
    output logic [4:0]      outstanding,
    output logic            err_unexpected_rdv
);

    localparam int unsigned IW = (NREQ > 2) ? 2 : 1;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(HOLD_MAX + 1);

    typedef enum logic {StIdle, StGranted} state_e;

    state_e        state;
    logic [IW-1:0] gidx;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] run_cnt;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          win_found;

    logic [IW-1:0] tag_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] tag_head;

    logic granted, g_read, g_write, read_block, accept, release_now;
    logic fifo_empty, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign granted    = (state == StGranted);
    assign g_read     = req_read[gidx];
    assign g_write    = req_write[gidx];
    assign read_block = (outstanding == 5'(MAX_OUTSTANDING));
    assign fifo_empty = (outstanding == '0);
    assign tag_head   = tag_mem[rd_ptr];

    // Master port follows the owner; reads are withheld while the tag FIFO is full.
    assign master_address    = req_address[gidx];
    assign master_byteenable = req_byteenable[gidx];
    assign master_writedata  = req_writedata[gidx];
    assign master_read       = granted & g_read & ~read_block;
    assign master_write      = granted & g_write;
    assign req_readdata      = master_readdata;

    assign accept      = (master_read | master_write) & ~master_waitrequest;
    assign push        = accept & master_read;
    assign pop         = master_readdatavalid & ~fifo_empty;
    assign release_now = granted &
                         ((~g_read & ~g_write) | (accept & (run_cnt == CW'(HOLD_MAX - 1))));

    // Pick the first active requester at or after rr_ptr, wrapping upward.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(rr_ptr) + k) % NREQ);
            if (!win_found && (req_read[cand] || req_write[cand])) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Per-requester stall and data-valid steering.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_waitrequest[i]   = 1'b1;
            req_readdatavalid[i] = 1'b0;
            if (granted && gidx == IW'(i)) begin
                req_waitrequest[i] = master_waitrequest | (g_read & read_block);
            end
            if (pop && tag_head == IW'(i)) begin
                req_readdatavalid[i] = 1'b1;
            end
        end
    end

    // Grant FSM: arbitrate in idle, count accepts while granted, release on idle strobes or cap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= StIdle;
            grant   <= '0;
            gidx    <= '0;
            rr_ptr  <= '0;
            run_cnt <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (win_found) begin
                        state   <= StGranted;
                        grant   <= NREQ'(1) << win_idx;
                        gidx    <= win_idx;
                        rr_ptr  <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                        run_cnt <= '0;
                    end
                end
                StGranted: begin
                    if (accept) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                    if (release_now) begin
                        state   <= StIdle;
                        grant   <= '0;
                        run_cnt <= '0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Tag storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[wr_ptr] <= gidx;
        end
    end

    // Tag FIFO pointers, in-flight count and sticky stray-return flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            outstanding        <= '0;
            err_unexpected_rdv <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                outstanding <= outstanding + 5'd1;
            end else if (pop && !push) begin
                outstanding <= outstanding - 5'd1;
            end
            if (master_readdatavalid && fifo_empty) begin
                err_unexpected_rdv <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rasterizer_bus_arbiter.sv
// Scoreboard bench for rasterizer_bus_arbiter (NREQ=3, MAX_OUTSTANDING=8, HOLD_MAX=4).
module tb_rasterizer_bus_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned MAXO = 8;
    localparam int unsigned HOLD = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [25:0]     req_address       [NREQ];
    logic            req_read          [NREQ];
    logic            req_write         [NREQ];
    logic [3:0]      req_byteenable    [NREQ];
    logic [31:0]     req_writedata     [NREQ];
    logic            req_waitrequest   [NREQ];
    logic [31:0]     req_readdata;
    logic            req_readdatavalid [NREQ];
    logic [25:0]     master_address;
    logic            master_read;
    logic            master_write;
    logic [3:0]      master_byteenable;
    logic [31:0]     master_writedata;
    logic [31:0]     master_readdata = '0;
    logic            master_readdatavalid = 1'b0;
    logic            master_waitrequest = 1'b0;
    logic [NREQ-1:0] grant;
    logic [4:0]      outstanding;
    logic            err_unexpected_rdv;

    rasterizer_bus_arbiter #(
        .NREQ            (NREQ),
        .MAX_OUTSTANDING (MAXO),
        .HOLD_MAX        (HOLD)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .req_address          (req_address),
        .req_read             (req_read),
        .req_write            (req_write),
        .req_byteenable       (req_byteenable),
        .req_writedata        (req_writedata),
        .req_waitrequest      (req_waitrequest),
        .req_readdata         (req_readdata),
        .req_readdatavalid    (req_readdatavalid),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_byteenable    (master_byteenable),
        .master_writedata     (master_writedata),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_waitrequest   (master_waitrequest),
        .grant                (grant),
        .outstanding          (outstanding),
        .err_unexpected_rdv   (err_unexpected_rdv)
    );

    always #5 clock = ~clock;

    typedef struct { int unsigned r; logic [31:0] data; } exp_t;
    typedef struct { int unsigned due; logic [25:0] addr; } pend_t;

    exp_t            exp_q[$];
    pend_t           rdq[$];
    logic [NREQ-1:0] glog[$];
    int              tests = 0;
    int              fails = 0;
    int unsigned     cyc = 0;
    logic            ret_en = 1'b0;
    logic            stray = 1'b0;
    logic            log_en = 1'b0;
    int unsigned     wr_acc = 0;
    logic [25:0]     wr_addr = '0;
    logic [31:0]     wr_data = '0;
    logic [NREQ-1:0] mon_vec;

    function automatic logic [31:0] mem_data(input logic [25:0] a);
        return {6'h2A, a};
    endfunction

    function automatic logic [NREQ-1:0] rdv_vec();
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = req_readdatavalid[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Memory model: records accepted reads/writes, returns read data after 3 cycles.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (master_read && !master_waitrequest) rdq.push_back('{due: cyc + 3, addr: master_address});
        if (master_write && !master_waitrequest) begin
            wr_acc  = wr_acc + 1;
            wr_addr = master_address;
            wr_data = master_writedata;
        end
    end

    always @(posedge clock) begin
        #2;
        master_readdatavalid = 1'b0;
        if (stray) begin
            master_readdatavalid = 1'b1;
            master_readdata      = 32'hBAD0_0000;
        end else if (ret_en && rdq.size() > 0 && rdq[0].due <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata      = mem_data(rdq[0].addr);
            void'(rdq.pop_front());
        end
    end

    // Grant trace recorder for the contention test.
    always @(negedge clock) begin
        if (log_en && glog.size() < 30) glog.push_back(grant);
    end

    // Scoreboard monitor: every data-valid pulse must match the oldest expected return.
    always @(negedge clock) begin
        mon_vec = rdv_vec();
        if (mon_vec != '0) begin
            if (exp_q.size() == 0) begin
                check("rdv_unexpected", 32'(mon_vec), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rdv_tag", 32'(mon_vec), 32'(1) << e.r);
                check("rdv_data", req_readdata, e.data);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Issues n sequential reads from requester r; called and returns just after a rising edge.
    task automatic issue_reads(input int unsigned r, input logic [25:0] base, input int unsigned n,
                               output logic [NREQ-1:0] g_first, output int unsigned wait_first);
        g_first    = '0;
        wait_first = 0;
        for (int unsigned i = 0; i < n; i++) begin
            bit          acc;
            int unsigned k;
            acc = 1'b0;
            k   = 0;
            req_read[r]    = 1'b1;
            req_address[r] = base + 26'(4 * i);
            while (!acc) begin
                @(negedge clock);
                if (!req_waitrequest[r]) begin
                    acc = 1'b1;
                    exp_q.push_back('{r: r, data: mem_data(req_address[r])});
                    if (i == 0) begin
                        g_first    = grant;
                        wait_first = k;
                    end
                end else begin
                    k++;
                end
                @(posedge clock); #1;
                if (!acc && k > 200) begin
                    check("accept_timeout", k, 0);
                    req_read[r] = 1'b0;
                    return;
                end
            end
        end
        req_read[r] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] g0, g1, g2;
        int unsigned     w0, w1, w2;
        logic [NREQ-1:0] eg;
        int unsigned     base_wr;
        bit              stable;

        for (int i = 0; i < NREQ; i++) begin
            req_read[i]       = 1'b0;
            req_write[i]      = 1'b0;
            req_address[i]    = '0;
            req_byteenable[i] = 4'hF;
            req_writedata[i]  = '0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_grant", 32'(grant), 0);
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_err", 32'(err_unexpected_rdv), 0);
        check("rst_mread", 32'(master_read), 0);
        check("rst_mwrite", 32'(master_write), 0);
        for (int i = 0; i < NREQ; i++) check("rst_waitreq", 32'(req_waitrequest[i]), 1);
        check("rst_rdv", 32'(rdv_vec()), 0);

        // Single reader: 15 reads 0x100..0x138, returns 3 cycles later
        ret_en = 1'b1;
        @(posedge clock); #1;
        issue_reads(0, 26'h100, 15, g0, w0);
        check("t1_grant", 32'(g0), 32'b001);
        check("t1_latency", w0, 1);
        repeat (12) @(posedge clock);
        #1;
        @(negedge clock);
        check("t1_outstanding", 32'(outstanding), 0);
        check("t1_drain", exp_q.size(), 0);

        // Contention: three continuous readers, runs of 4 with one bubble between
        do_reset();
        log_en = 1'b1;
        fork
            issue_reads(0, 26'h1000, 8, g0, w0);
            issue_reads(1, 26'h2000, 8, g1, w1);
            issue_reads(2, 26'h3000, 8, g2, w2);
        join
        log_en = 1'b0;
        check("t2_trace_len", glog.size(), 30);
        for (int c = 0; c < 30 && c < glog.size(); c++) begin
            if (c == 0 || ((c - 1) % 5) == 4) eg = '0;
            else eg = NREQ'(1) << (((c - 1) / 5) % 3);
            check($sformatf("t2_grant_c%0d", c), 32'(glog[c]), 32'(eg));
        end
        repeat (12) @(posedge clock);
        #1;
        check("t2_outstanding", 32'(outstanding), 0);
        check("t2_drain", exp_q.size(), 0);

        // Interleaved returns after ownership changes
        do_reset();
        ret_en = 1'b0;
        issue_reads(1, 26'h200, 2, g1, w1);
        issue_reads(2, 26'h300, 2, g2, w2);
        check("t3_outstanding4", 32'(outstanding), 4);
        ret_en = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check("t3_outstanding0", 32'(outstanding), 0);
        check("t3_drain", exp_q.size(), 0);

        // Outstanding cap: ninth read stalls until one return
        do_reset();
        ret_en = 1'b0;
        issue_reads(0, 26'h400, 8, g0, w0);
        check("t4_full", 32'(outstanding), 8);
        req_read[0]    = 1'b1;
        req_address[0] = 26'h420;
        @(negedge clock);
        @(negedge clock);
        check("t4_grant", 32'(grant), 32'b001);
        check("t4_blocked_mread", 32'(master_read), 0);
        check("t4_blocked_wait", 32'(req_waitrequest[0]), 1);
        @(posedge clock); #1;
        ret_en = 1'b1;
        @(negedge clock);
        check("t4_still_blocked", 32'(master_read), 0);
        @(posedge clock); #1;
        ret_en = 1'b0;
        @(negedge clock);
        check("t4_mread", 32'(master_read), 1);
        check("t4_accept", 32'(req_waitrequest[0]), 0);
        check("t4_out7", 32'(outstanding), 7);
        exp_q.push_back('{r: 0, data: mem_data(26'h420)});
        @(posedge clock); #1;
        req_read[0] = 1'b0;
        @(negedge clock);
        check("t4_out8", 32'(outstanding), 8);
        ret_en = 1'b1;
        repeat (15) @(posedge clock);
        #1;
        check("t4_drain_out", 32'(outstanding), 0);
        check("t4_drain", exp_q.size(), 0);

        // Waitrequest stall on a write, then a stray return
        base_wr            = wr_acc;
        master_waitrequest = 1'b1;
        req_write[2]       = 1'b1;
        req_address[2]     = 26'h40;
        req_writedata[2]   = 32'hDEADBEEF;
        req_byteenable[2]  = 4'hF;
        @(negedge clock);
        stable = 1'b1;
        repeat (5) begin
            @(posedge clock); #1;
            @(negedge clock);
            if (!(master_write && !master_read && master_address == 26'h40 &&
                  master_writedata == 32'hDEADBEEF && master_byteenable == 4'hF &&
                  req_waitrequest[2] && grant == 3'b100)) stable = 1'b0;
        end
        check("t5_stable", 32'(stable), 1);
        @(posedge clock); #1;
        master_waitrequest = 1'b0;
        @(negedge clock);
        check("t5_accept", 32'(req_waitrequest[2]), 0);
        @(posedge clock); #1;
        req_write[2] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("t5_once", wr_acc - base_wr, 1);
        check("t5_addr", 32'(wr_addr), 32'h40);
        check("t5_data", wr_data, 32'hDEADBEEF);
        check("t5_err_before", 32'(err_unexpected_rdv), 0);
        stray = 1'b1;
        @(negedge clock);
        check("t5_stray_no_rdv", 32'(rdv_vec()), 0);
        @(posedge clock); #1;
        stray = 1'b0;
        @(negedge clock);
        check("t5_err_set", 32'(err_unexpected_rdv), 1);
        check("t5_out", 32'(outstanding), 0);

        // Reset mid-run with reads in flight
        @(posedge clock); #1;
        do_reset();
        check("t6_err_cleared", 32'(err_unexpected_rdv), 0);
        ret_en = 1'b0;
        issue_reads(1, 26'h500, 3, g1, w1);
        check("t6_out3", 32'(outstanding), 3);
        req_read[1]    = 1'b1;
        req_address[1] = 26'h50C;
        reset          = 1'b1;
        exp_q.delete();
        @(posedge clock); #1;
        reset       = 1'b0;
        req_read[1] = 1'b0;
        @(negedge clock);
        check("t6_grant", 32'(grant), 0);
        check("t6_out0", 32'(outstanding), 0);
        ret_en = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check("t6_err", 32'(err_unexpected_rdv), 1);
        check("t6_out_after", 32'(outstanding), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
